// File: rtl/note_seq_pkg.sv
// rtl/note_seq_pkg.sv - shared types and default sizing for the note sequencer
package note_seq_pkg;

    localparam int DEPTH    = 16;
    localparam int DIV_W    = 9;
    localparam int DUR_W    = 8;
    localparam int TICK_DIV = 20000;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PLAY,
        END
    } state_e;

    // One note-table entry: div==0 is a rest, dur==0 marks end of sequence
    typedef struct packed {
        logic [DIV_W-1:0] div;
        logic [DUR_W-1:0] dur;
    } entry_t;

endpackage

// File: rtl/note_sequencer_if.sv
// rtl/note_sequencer_if.sv - host-side table/control and playback status bundle
interface note_sequencer_if #(
    parameter int DEPTH = note_seq_pkg::DEPTH
);
    import note_seq_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);

    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [DIV_W-1:0] wr_div;
    logic [DUR_W-1:0] wr_dur;
    logic             start;
    logic             stop;
    logic             loop;
    logic [7:0]       phase;
    logic             mute;
    logic             busy;
    logic [IDX_W-1:0] note_idx;
    logic             done;

    modport master (
        output wr_en, wr_addr, wr_div, wr_dur, start, stop, loop,
        input  phase, mute, busy, note_idx, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_div, wr_dur, start, stop, loop,
        output phase, mute, busy, note_idx, done
    );

endinterface

// File: rtl/phase_stepper.sv
// rtl/phase_stepper.sv - divides clk into phase-index steps for one voice
module phase_stepper
    import note_seq_pkg::*;
#(
    parameter int STEP_W = DIV_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic              zero_i,
    input  logic [STEP_W-1:0] div_i,
    output logic [7:0]        phase_o
);

    logic [STEP_W-1:0] step_q, step_d;
    logic [7:0]        phase_q, phase_d;

    // Step counter wraps at div; each wrap advances the phase unless the note is a rest
    always_comb begin
        step_d  = step_q;
        phase_d = phase_q;
        if (zero_i) begin
            phase_d = '0;
        end
        if (clr_i) begin
            step_d = '0;
        end else if (en_i) begin
            if (step_q == div_i) begin
                step_d = '0;
                if (div_i != '0) begin
                    phase_d = phase_q + 8'd1;
                end
            end else begin
                step_d = step_q + 1'b1;
            end
        end
    end

    // Counter and phase registers
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q  <= '0;
            phase_q <= '0;
        end else begin
            step_q  <= step_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - plays a programmable note table into the sine phase index
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int DEPTH    = note_seq_pkg::DEPTH,
    parameter int TICK_DIV = note_seq_pkg::TICK_DIV
) (
    input  logic               clk,
    input  logic               rst,
    note_sequencer_if.slave    bus
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             loop_q, loop_d;
    entry_t           cur_q, cur_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic             done_q, done_d;
    entry_t           table_q [DEPTH];

    entry_t           fetch_e;
    logic             tick_wrap;
    logic             note_last;
    logic             st_en, st_clr, st_zero;
    logic [7:0]       phase_w;

    assign fetch_e   = table_q[idx_q];
    assign tick_wrap = (tick_q == TICK_W'(TICK_DIV - 1));
    // cur_q.dur is non-zero whenever PLAY is active, so the subtraction cannot wrap
    assign note_last = tick_wrap && (dur_q == cur_q.dur - 1'b1);

    // Table is host-owned storage: written at any time, never cleared by reset
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            table_q[bus.wr_addr] <= entry_t'({bus.wr_div, bus.wr_dur});
        end
    end

    // Sequencer next-state: fetch, play for dur ticks, advance or end; stop overrides all
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        loop_d  = loop_q;
        cur_d   = cur_q;
        tick_d  = tick_q;
        dur_d   = dur_q;
        done_d  = 1'b0;
        st_en   = 1'b0;
        st_clr  = 1'b0;
        st_zero = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d = FETCH;
                    idx_d   = '0;
                    loop_d  = bus.loop;
                    st_zero = 1'b1;
                end
            end
            FETCH: begin
                cur_d = fetch_e;
                if (fetch_e.dur == '0) begin
                    state_d = END;
                end else begin
                    state_d = PLAY;
                    tick_d  = '0;
                    dur_d   = '0;
                    st_clr  = 1'b1;
                end
            end
            PLAY: begin
                st_en  = 1'b1;
                tick_d = tick_wrap ? '0 : tick_q + 1'b1;
                if (tick_wrap) begin
                    dur_d = dur_q + 1'b1;
                end
                if (note_last) begin
                    if (idx_q == IDX_W'(DEPTH - 1)) begin
                        state_d = END;
                    end else begin
                        state_d = FETCH;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            END: begin
                if (loop_q) begin
                    state_d = FETCH;
                    idx_d   = '0;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort freezes phase and note index where they are
        if (bus.stop && state_q != IDLE) begin
            state_d = IDLE;
            idx_d   = idx_q;
            done_d  = 1'b0;
            st_en   = 1'b0;
            st_clr  = 1'b0;
        end
    end

    // Sequencer state and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            loop_q  <= 1'b0;
            cur_q   <= '0;
            tick_q  <= '0;
            dur_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            loop_q  <= loop_d;
            cur_q   <= cur_d;
            tick_q  <= tick_d;
            dur_q   <= dur_d;
            done_q  <= done_d;
        end
    end

    phase_stepper #(
        .STEP_W (DIV_W)
    ) u_stepper (
        .clk     (clk),
        .rst     (rst),
        .en_i    (st_en),
        .clr_i   (st_clr),
        .zero_i  (st_zero),
        .div_i   (cur_q.div),
        .phase_o (phase_w)
    );

    assign bus.phase    = phase_w;
    assign bus.mute     = !(state_q == PLAY && cur_q.div != '0);
    assign bus.busy     = (state_q != IDLE);
    assign bus.note_idx = idx_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - self-checking bench for note_sequencer
module tb_note_sequencer;
    import note_seq_pkg::*;

    localparam int T  = 4;
    localparam int N  = 200;
    localparam int IW = $clog2(DEPTH);
    localparam int VW = IW + 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   m_div [DEPTH];
    int   m_dur [DEPTH];
    logic [VW-1:0] e_vec [N];
    logic [VW-1:0] a_vec [N];
    int   glen;

    note_sequencer_if #(.DEPTH(DEPTH)) bus ();

    note_sequencer #(.DEPTH(DEPTH), .TICK_DIV(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_write(input int a, input int dv, input int du);
        bus.wr_en   = 1'b1;
        bus.wr_addr = IW'(a);
        bus.wr_div  = DIV_W'(dv);
        bus.wr_dur  = DUR_W'(du);
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic write_entry(input int a, input int dv, input int du);
        m_div[a] = dv;
        m_dur[a] = du;
        drive_write(a, dv, du);
    endtask

    task automatic put(input bit b, input bit m, input int p, input int i, input bit d);
        if (glen < N) begin
            e_vec[glen] = {b, m, p[7:0], i[IW-1:0], d};
            glen++;
        end
    endtask

    // Reference: expand the note list into per-cycle {busy,mute,phase,idx,done}, cycle 0 = first FETCH
    task automatic gen_expect(input bit lp, input int n);
        int p, idx, v, d;
        bit fin;
        glen = 0; p = 0; idx = 0; fin = 1'b0;
        while (glen < n && !fin) begin
            put(1, 1, p, idx, 0);
            v = m_div[idx];
            d = m_dur[idx];
            if (d != 0) begin
                for (int k = 0; k < d * T; k++)
                    put(1, v == 0, (v == 0) ? p : (p + k / (v + 1)) % 256, idx, 0);
                if (v != 0) p = (p + (d * T) / (v + 1)) % 256;
                if (idx < DEPTH - 1) begin
                    idx++;
                    continue;
                end
            end
            put(1, 1, p, idx, 0);
            if (lp) idx = 0;
            else fin = 1'b1;
        end
        if (fin) put(0, 1, p, idx, 1);
        while (glen < n) put(0, 1, p, idx, 0);
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            a_vec[i] = {bus.busy, bus.mute, bus.phase, bus.note_idx, bus.done};
            tick();
        end
    endtask

    task automatic kick(input bit lp);
        bus.loop  = lp;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.loop  = 1'b0;
    endtask

    task automatic quiesce();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        tick();
    endtask

    task automatic load_basic();
        write_entry(0, 2, 3);
        write_entry(1, 0, 2);
        write_entry(2, 5, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
        tests++; if (bus.mute !== 1'b1) begin fails++; $display("FAIL reset_mute got %b expected 1", bus.mute); end
        tests++; if (bus.phase !== 8'd0) begin fails++; $display("FAIL reset_phase got %0d expected 0", bus.phase); end
        tests++; if (bus.note_idx !== '0) begin fails++; $display("FAIL reset_idx got %0d expected 0", bus.note_idx); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b expected 0", bus.done); end
        rst = 1'b0;
        tick();
        for (int a = 0; a < DEPTH; a++) write_entry(a, 0, 0);
    endtask

    task automatic test_basic();
        load_basic();
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL basic_idle_busy got %b expected 0", bus.busy); end
        gen_expect(0, 30);
        kick(0);
        capture(30);
        for (int i = 0; i < 30; i++) begin
            tests++;
            if (a_vec[i] !== e_vec[i]) begin
                fails++;
                $display("FAIL basic_trace cycle %0d got %h expected %h", i, a_vec[i], e_vec[i]);
            end
        end
        quiesce();
    endtask

    task automatic test_loop();
        load_basic();
        gen_expect(1, 70);
        kick(1);
        fork
            capture(70);
            begin
                repeat (20) tick();
                bus.start = 1'b1;
                tick();
                bus.start = 1'b0;
            end
        join
        for (int i = 0; i < 70; i++) begin
            tests++;
            if (a_vec[i] !== e_vec[i]) begin
                fails++;
                $display("FAIL loop_trace cycle %0d got %h expected %h", i, a_vec[i], e_vec[i]);
            end
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        tests++; if (bus.busy !== 1'b0 || bus.mute !== 1'b1) begin fails++; $display("FAIL loop_stop busy=%b mute=%b expected 0/1", bus.busy, bus.mute); end
        tick();
    endtask

    task automatic test_stop_start();
        logic [7:0] ph;
        bit saw_done, moved;
        load_basic();
        gen_expect(0, 10);
        ph = e_vec[6][IW+8:IW+1];
        kick(0);
        repeat (6) tick();
        bus.stop  = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL collide_busy got %b expected 0", bus.busy); end
        tests++; if (bus.mute !== 1'b1) begin fails++; $display("FAIL collide_mute got %b expected 1", bus.mute); end
        tests++; if (bus.phase !== ph) begin fails++; $display("FAIL collide_phase got %0d expected %0d", bus.phase, ph); end
        saw_done = 1'b0;
        moved    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) saw_done = 1'b1;
            if (bus.phase !== ph || bus.busy !== 1'b0) moved = 1'b1;
            tick();
        end
        tests++; if (saw_done) begin fails++; $display("FAIL collide_done got pulse expected none"); end
        tests++; if (moved) begin fails++; $display("FAIL collide_frozen got activity expected frozen phase %0d", ph); end
    endtask

    task automatic test_wrap();
        int busy_cnt;
        for (int a = 0; a < DEPTH; a++) write_entry(a, 0, 1);
        gen_expect(0, 90);
        kick(0);
        capture(90);
        busy_cnt = 0;
        for (int i = 0; i < 90; i++) begin
            busy_cnt += int'(a_vec[i][VW-1]);
            tests++;
            if (a_vec[i] !== e_vec[i]) begin
                fails++;
                $display("FAIL wrap_trace cycle %0d got %h expected %h", i, a_vec[i], e_vec[i]);
            end
        end
        tests++;
        if (busy_cnt != DEPTH * (T + 1) + 1) begin
            fails++;
            $display("FAIL wrap_busy_len got %0d expected %0d", busy_cnt, DEPTH * (T + 1) + 1);
        end
        quiesce();
    endtask

    task automatic test_write_during_play();
        write_entry(0, 3, 2);
        write_entry(1, 4, 2);
        write_entry(2, 5, 0);
        m_div[1] = 1;
        gen_expect(0, 40);
        kick(0);
        fork
            capture(40);
            begin
                repeat (2) tick();
                drive_write(1, 1, 2);
                tick();
                drive_write(0, 7, 1);
            end
        join
        m_div[0] = 7;
        m_dur[0] = 1;
        for (int i = 0; i < 40; i++) begin
            tests++;
            if (a_vec[i] !== e_vec[i]) begin
                fails++;
                $display("FAIL wrplay_trace cycle %0d got %h expected %h", i, a_vec[i], e_vec[i]);
            end
        end
        quiesce();
    endtask

    task automatic test_reset_mid();
        load_basic();
        kick(0);
        repeat (15) tick();
        rst = 1'b1;
        tick();
        tests++; if (bus.phase !== 8'd0) begin fails++; $display("FAIL rstmid_phase got %0d expected 0", bus.phase); end
        tests++; if (bus.mute !== 1'b1) begin fails++; $display("FAIL rstmid_mute got %b expected 1", bus.mute); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b expected 0", bus.busy); end
        tests++; if (bus.note_idx !== '0) begin fails++; $display("FAIL rstmid_idx got %0d expected 0", bus.note_idx); end
        rst = 1'b0;
        tick();
        gen_expect(0, 30);
        kick(0);
        capture(30);
        for (int i = 0; i < 30; i++) begin
            tests++;
            if (a_vec[i] !== e_vec[i]) begin
                fails++;
                $display("FAIL rstmid_replay cycle %0d got %h expected %h", i, a_vec[i], e_vec[i]);
            end
        end
        quiesce();
    endtask

    task automatic test_random();
        bit lp;
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < DEPTH; a++)
                write_entry(a, $urandom_range(0, 6), ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 3));
            lp = 1'($urandom_range(0, 1));
            gen_expect(lp, 150);
            kick(lp);
            capture(150);
            for (int i = 0; i < 150; i++) begin
                tests++;
                if (a_vec[i] !== e_vec[i]) begin
                    fails++;
                    $display("FAIL random%0d_trace cycle %0d got %h expected %h", r, i, a_vec[i], e_vec[i]);
                end
            end
            bus.stop = 1'b1;
            tick();
            bus.stop = 1'b0;
            tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL random%0d_stop busy got %b expected 0", r, bus.busy); end
            tick();
        end
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_div  = '0;
        bus.wr_dur  = '0;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.loop    = 1'b0;
        test_reset();
        test_basic();
        test_loop();
        test_stop_start();
        test_wrap();
        test_write_during_play();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Plays a programmable list of notes by driving the 8-bit phase index into the sine lookup. The sine lookup feeds the delta-sigma modulator.
- Replaces the fixed-pitch phase stepper. Each table entry holds a step divider (pitch) and a duration (ms ticks).
- A host or boot logic writes the table, then issues start/stop. The block sequences entries, optionally looping, and reports progress.

Parameters:
- DEPTH, 16, number of note-table entries (power of two).
- DIV_W, 9, width of the per-entry phase-step divider.
- DUR_W, 8, width of the per-entry duration in ticks.
- TICK_DIV, 20000, clk cycles per duration tick (1 ms at 20 MHz).

Ports:
- clk  in  1  system clock (20 MHz)
- rst  in  1  synchronous active-high reset
- wr_en  in  1  table write strobe
- wr_addr  in  log2(DEPTH)  table entry to write
- wr_div  in  DIV_W  divider for entry; 0 = rest
- wr_dur  in  DUR_W  duration in ticks; 0 = end-of-sequence marker
- start  in  1  begin playback at entry 0 (pulse)
- stop  in  1  abort playback (pulse)
- loop  in  1  sampled at start; 1 = restart at entry 0 on end
- phase  out  8  sine-table phase index
- mute  out  1  1 = downstream forces midscale PCM
- busy  out  1  sequence active
- note_idx  out  log2(DEPTH)  entry currently playing
- done  out  1  one-cycle pulse on natural sequence end (not on stop)

Behaviour:
- Reset values: phase=0, mute=1, busy=0, done=0, note_idx=0, state=IDLE. All internal counters are 0.
- Table contents are not reset; registers are written on wr_en at any time.
- A write takes effect the next time that entry is fetched. A write to the currently playing entry does not alter the note in progress.
- States:
  - IDLE: mute=1, phase holds.
  - start -> FETCH. Load idx=0, phase=0, latch loop, busy=1 on the next cycle.
  - start while busy is ignored.
- FETCH (1 cycle):
  - Read entry[idx] into cur_div and cur_dur; mute=1.
  - If cur_dur==0 -> END.
  - Otherwise -> PLAY, clearing step_cnt, tick_cnt and dur_cnt.
- PLAY:
  - mute = (cur_div==0).
  - step_cnt counts 0..cur_div. At cur_div it wraps to 0 and phase increments mod 256, giving one phase step per cur_div+1 cycles.
  - For a rest, phase holds.
  - tick_cnt counts 0..TICK_DIV-1. On wrap, dur_cnt increments.
  - When dur_cnt reaches cur_dur, the next state is FETCH: idx+1, or END if idx==DEPTH-1.
  - PLAY lasts exactly cur_dur*TICK_DIV cycles.
  - phase is not reset between notes, which keeps the waveform continuous.
- END (1 cycle):
  - If loop_latched -> FETCH with idx=0, no done.
  - Otherwise done=1, busy=0 next cycle -> IDLE.
- stop in any non-IDLE state -> IDLE on the next cycle: mute=1, busy=0, no done, phase holds.
- stop and start in the same cycle: stop wins, and the block stays or goes IDLE.
- rst mid-operation returns all outputs to their reset values on the next edge. Table contents are preserved.
- note_idx reflects idx in FETCH, PLAY and END, and holds its last value in IDLE.

Decomposition:
- Shared package note_seq_pkg holds:
  - state enum (IDLE, FETCH, PLAY, END);
  - entry struct {div[DIV_W], dur[DUR_W]};
  - default constants DEPTH, DIV_W, DUR_W, TICK_DIV.
- Sub-module phase_stepper: step_cnt plus phase register, with enable, clear and div inputs. It is reused for any future multi-voice variant.
- Sequencer FSM, table and duration counters live in the top of note_sequencer.

Test Plan:
All scenarios use TICK_DIV=4.
- Basic sequence:
  - Stimulus: entries {div=2,dur=3}, {div=0,dur=2}, {div=5,dur=0}; start.
  - Response: busy rises next cycle; 12 PLAY cycles with phase stepping every 3 cycles (phase=4 at note end); 1 FETCH with mute=1; 8 cycles mute=1 with phase held at 4; then done pulse and busy=0.
- Loop:
  - Stimulus: same table, loop=1 at start.
  - Response: after entry 1, END returns to entry 0 with no done. note_idx sequence is 0,1,0,1,... phase continues from 4, not reset.
- Stop/start collision:
  - Stimulus: during PLAY of entry 0, assert stop and start together.
  - Response: IDLE next cycle, busy=0, mute=1, done never pulses, phase frozen.
- Table wrap:
  - Stimulus: all 16 entries {div=0,dur=1}, loop=0.
  - Response: after idx 15, END then done; total busy time 16*(4+1)+1 cycles.
- Write during play:
  - Stimulus: rewrite entry 1 to div=1 while entry 0 plays.
  - Response: entry 1 plays with a step every 2 cycles. Rewriting entry 0 mid-note leaves the current note unchanged.
- Reset mid-play:
  - Stimulus: assert rst in PLAY.
  - Response: phase=0, mute=1, busy=0, note_idx=0 next edge. A subsequent start replays the unchanged table.
